// File: rtl/seg_pkg.sv
// Shared types and helpers for the seven-segment scan path.
// Contents: nibble_t, anode_vec_t, MAX_DIGITS, ANODE_ALL_OFF,
//           anode_all_off(n) (all-ones vector for n digits), onehot_n(idx) (active-low select).
package seg_pkg;

  localparam int unsigned MAX_DIGITS = 8;
  localparam int unsigned MAX_IDX_W  = 3;

  typedef logic [3:0]            nibble_t;
  typedef logic [MAX_DIGITS-1:0] anode_vec_t;

  // All-ones anode vector covering the low n digits; upper bits stay zero.
  function automatic anode_vec_t anode_all_off(input int unsigned n);
    anode_vec_t v;
    v = '0;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      if (i < n) v[i] = 1'b1;
    end
    return v;
  endfunction

  localparam anode_vec_t ANODE_ALL_OFF = anode_all_off(MAX_DIGITS);

  // Active-low one-hot anode select for digit idx.
  function automatic anode_vec_t onehot_n(input logic [MAX_IDX_W-1:0] idx);
    return ~(anode_vec_t'(1) << idx);
  endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// Free-running prescaler: counts 0..DIV-1 and flags the last count of each period.
// Ports: clk, reset (sync, active-high), tick (comb, high when cnt == DIV-1), cnt (current count).
module seg_tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   tick,
  output logic [$clog2(DIV)-1:0] cnt
);

  localparam int unsigned CNT_W = $clog2(DIV);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             wrap_c;

  // Wrap detection and next count.
  always_comb begin
    wrap_c = (cnt_q == CNT_W'(DIV - 1));
    cnt_d  = wrap_c ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = wrap_c;
  assign cnt  = cnt_q;

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed seven-segment scanner feeding the hex-to-cathode decoder.
// Shadows value/blank_mask on load, steps one digit per REFRESH_DIV cycles, holds all
// anodes off for the first GUARD_CYCLES of each slot, and pulses frame_done on wrap.
// Ports: clk, reset (sync, active-high), value[4*NUM_DIGITS-1:0], blank_mask, load,
//        digit[3:0], anode (active-low), frame_done. All outputs registered.
// Optional: SEG_SCAN_LEADING_ZERO_BLANK_EN auto-blanks leading zero digits (never digit 0).
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned GUARD_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    load,
  output logic [3:0]              digit,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_done
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = NUM_DIGITS'(anode_all_off(NUM_DIGITS));

  logic                           tick_c;
  logic [CNT_W-1:0]               cnt_c;
  logic                           in_guard_c;
  logic [NUM_DIGITS-1:0]          eff_mask_c;

  logic [IDX_W-1:0]               idx_q,         idx_d;
  logic [NUM_DIGITS-1:0][3:0]     shadow_val_q,  shadow_val_d;
  logic [NUM_DIGITS-1:0]          shadow_mask_q, shadow_mask_d;
  nibble_t                        digit_q,       digit_d;
  logic [NUM_DIGITS-1:0]          anode_q,       anode_d;
  logic                           frame_done_q,  frame_done_d;

  seg_tick_gen #(
    .DIV (REFRESH_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick_c),
    .cnt   (cnt_c)
  );

  // Guard window at the start of every slot; a zero-length guard never blanks.
  generate
    if (GUARD_CYCLES == 0) begin : g_no_guard
      assign in_guard_c = 1'b0;
    end else begin : g_guard
      assign in_guard_c = (cnt_c < CNT_W'(GUARD_CYCLES));
    end
  endgenerate

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_c;
  logic                  zero_run_c;

  // Walk down from the top digit; a digit is leading-zero while every digit at or above it is 0.
  always_comb begin
    lz_c       = '0;
    zero_run_c = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
      zero_run_c = zero_run_c & (shadow_val_q[i] == 4'h0);
      lz_c[i]    = zero_run_c;
    end
  end

  assign eff_mask_c = shadow_mask_q | lz_c;
`else
  assign eff_mask_c = shadow_mask_q;
`endif

  // Next-state for index, shadows and registered outputs.
  always_comb begin
    idx_d         = idx_q;
    shadow_val_d  = shadow_val_q;
    shadow_mask_d = shadow_mask_q;
    frame_done_d  = 1'b0;

    if (tick_c) begin
      if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
        idx_d        = '0;
        frame_done_d = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    if (load) begin
      shadow_val_d  = value;
      shadow_mask_d = blank_mask;
    end

    digit_d = shadow_val_q[idx_q];
    if (in_guard_c || eff_mask_c[idx_q]) begin
      anode_d = ANODE_OFF;
    end else begin
      anode_d = NUM_DIGITS'(onehot_n(MAX_IDX_W'(idx_q)));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q         <= '0;
      shadow_val_q  <= '0;
      shadow_mask_q <= '0;
      digit_q       <= 4'h0;
      anode_q       <= ANODE_OFF;
      frame_done_q  <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      shadow_val_q  <= shadow_val_d;
      shadow_mask_q <= shadow_mask_d;
      digit_q       <= digit_d;
      anode_q       <= anode_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign digit      = digit_q;
  assign anode      = anode_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Testbench for seg_scan_mux with NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=1.
// Stimulus pushes the expected output for each clock edge into a queue; a monitor on the
// falling edge pops and compares digit, anode and frame_done.
module tb_seg_scan_mux;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int GC = 1;

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  localparam logic [3:0] LZ_ZERO = 4'b1110;
  localparam logic [3:0] LZ_0070 = 4'b1100;
`else
  localparam logic [3:0] LZ_ZERO = 4'b0000;
  localparam logic [3:0] LZ_0070 = 4'b0000;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] value;
  logic [3:0]  blank_mask;
  logic [3:0]  digit;
  logic [3:0]  anode;
  logic        frame_done;

  typedef struct packed {
    logic [15:0] tag;
    logic [3:0]  digit;
    logic [3:0]  anode;
    logic        fd;
  } exp_t;

  exp_t        sb_q[$];
  int          checks   = 0;
  int          failures = 0;

  int          n;
  logic [15:0] sh_val;
  logic [3:0]  sh_mask;
  logic [3:0]  sh_lz;
  logic [3:0]  in_lz;

  always #5 clk = ~clk;

  seg_scan_mux #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .GUARD_CYCLES (GC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .blank_mask (blank_mask),
    .load       (load),
    .digit      (digit),
    .anode      (anode),
    .frame_done (frame_done)
  );

  // Hand table of lit anode patterns per digit slot.
  function automatic logic [3:0] act_pat(input int ix);
    case (ix)
      0:       return 4'b1110;
      1:       return 4'b1101;
      2:       return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  // Advance one clock edge and queue the output expected right after it.
  task automatic step();
    exp_t        e;
    int          c;
    int          ix;
    logic [15:0] v;
    @(posedge clk);
    #1;
    if (reset) begin
      n       = 0;
      sh_val  = 16'h0000;
      sh_mask = 4'b0000;
      sh_lz   = LZ_ZERO;
      e.tag   = 16'hFFFF;
      e.digit = 4'h0;
      e.anode = 4'b1111;
      e.fd    = 1'b0;
    end else begin
      n++;
      c       = (n - 1) % RD;
      ix      = ((n - 1) / RD) % ND;
      v       = sh_val >> (4 * ix);
      e.tag   = 16'(n);
      e.digit = v[3:0];
      e.anode = (c < GC || sh_mask[ix] || sh_lz[ix]) ? 4'b1111 : act_pat(ix);
      e.fd    = ((n % (RD * ND)) == 0);
      if (load) begin
        sh_val  = value;
        sh_mask = blank_mask;
        sh_lz   = in_lz;
      end
    end
    sb_q.push_back(e);
  endtask

  // Monitor: compare every queued expectation against the settled outputs.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checks++;
      if (digit !== e.digit) begin
        failures++;
        $display("FAIL digit n=%0d got=%h exp=%h", e.tag, digit, e.digit);
      end
      checks++;
      if (anode !== e.anode) begin
        failures++;
        $display("FAIL anode n=%0d got=%b exp=%b", e.tag, anode, e.anode);
      end
      checks++;
      if (frame_done !== e.fd) begin
        failures++;
        $display("FAIL frame_done n=%0d got=%b exp=%b", e.tag, frame_done, e.fd);
      end
    end
  end

  initial begin
    reset      = 1'b1;
    load       = 1'b0;
    value      = 16'h0000;
    blank_mask = 4'b0000;
    in_lz      = LZ_ZERO;
    n          = 0;
    sh_val     = 16'h0000;
    sh_mask    = 4'b0000;
    sh_lz      = LZ_ZERO;

    // Reset, then two idle frames.
    step();
    step();
    reset = 1'b0;
    repeat (32) step();

    // Plain value, no mask.
    value = 16'hA3F5; blank_mask = 4'b0000; in_lz = 4'b0000; load = 1'b1;
    step();
    load = 1'b0;
    repeat (20) step();

    // Masked digit 2.
    value = 16'h1234; blank_mask = 4'b0100; in_lz = 4'b0000; load = 1'b1;
    step();
    load = 1'b0;
    repeat (20) step();

    // Reset mid-scan at idx=2, cnt=2.
    while ((n % (RD * ND)) != 10) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (18) step();

    // Load coinciding with the slot tick.
    value = 16'h0000; blank_mask = 4'b0000; in_lz = LZ_ZERO; load = 1'b1;
    step();
    load = 1'b0;
    while ((n % RD) != (RD - 1)) step();
    value = 16'hFFFF; in_lz = 4'b0000; load = 1'b1;
    step();
    load = 1'b0;
    repeat (6) step();

    // Leading-zero values.
    value = 16'h0070; in_lz = LZ_0070; load = 1'b1;
    step();
    load = 1'b0;
    repeat (17) step();
    value = 16'h0000; in_lz = LZ_ZERO; load = 1'b1;
    step();
    load = 1'b0;
    repeat (17) step();

    // Load held high recaptures every cycle.
    in_lz = 4'b0000;
    load  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      value = 16'(16'h1111 * (k + 1));
      step();
    end
    load = 1'b0;
    repeat (6) step();

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d exp=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Time-multiplexed display scanner that sits directly upstream of the hex-to-cathode decoder.
- Captures a packed hex value and a per-digit blank mask into shadow registers.
- Steps through the digits at a fixed refresh rate and drives the active-low anodes.
- Presents the selected nibble on `digit` for the decoder. Includes an anti-ghosting guard interval at the start of each digit slot.

Parameters:
- NUM_DIGITS, 8: number of display digits scanned (range 2..8).
- REFRESH_DIV, 100000: clock cycles per digit slot (at least 2).
- GUARD_CYCLES, 1000: cycles at the start of each slot with all anodes off (must be less than REFRESH_DIV).

Ports:
- clk  in  1  system clock. All logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- value  in  4*NUM_DIGITS  packed hex value. Digit i is value[4*i+3:4*i]; digit 0 is rightmost.
- blank_mask  in  NUM_DIGITS  1 = digit i is never lit.
- load  in  1  single-cycle strobe that captures value and blank_mask into the shadow registers.
- digit  out  4  nibble for the current digit, fed to the cathode decoder.
- anode  out  NUM_DIGITS  active-low digit enables. At most one bit is low at any time.
- frame_done  out  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to digit 0.

Behaviour:
- Clock is clk; reset is synchronous, active-high (already decided).
- Reset values:
  - prescaler count = 0, idx = 0.
  - shadow value = 0, shadow mask = 0.
  - digit = 4'h0, anode = all ones, frame_done = 0.
  - Reset asserted mid-scan returns every register to these values on the next edge. No partial frame or pulse leaks out.
- Prescaler:
  - cnt increments each cycle and wraps at REFRESH_DIV-1 to 0.
  - tick = (cnt == REFRESH_DIV-1).
- Digit index:
  - On tick, idx increments; it wraps from NUM_DIGITS-1 to 0.
  - frame_done is registered and high the cycle after a tick in which idx wraps.
- Shadow registers:
  - On load, shadow value and shadow mask are replaced. The new contents are used from the next cycle.
  - load and tick in the same cycle: both take effect. The new idx shows the new data.
  - load held high simply recaptures every cycle.
- Outputs (registered, one-cycle latency from cnt, idx and shadow):
  - digit = shadow nibble at idx, always driven, including during the guard interval.
  - anode = all ones if cnt < GUARD_CYCLES or the shadow mask bit at idx is 1.
  - Otherwise anode = ~(1 << idx).
- Boundaries:
  - GUARD_CYCLES = 0 disables the guard.
  - No anode is ever low for two different digits in the same cycle.
  - Widths: cnt is $clog2(REFRESH_DIV) bits; idx is $clog2(NUM_DIGITS) bits, minimum 1.
  - For non-power-of-2 NUM_DIGITS, idx never reaches NUM_DIGITS.

Optional Feature:
- Macro: SEG_SCAN_LEADING_ZERO_BLANK_EN.
- When defined:
  - Each digit whose shadow nibble is 0 and whose higher-index digits are all 0 is blanked, as if its mask bit were set.
  - Digit 0 is never auto-blanked.
  - The effective mask is computed combinationally from the shadow value and ORed with the shadow mask.
- When undefined: only blank_mask blanks digits.

Decomposition:
- Shared package seg_pkg holds:
  - localparam ANODE_ALL_OFF (all ones, sized by NUM_DIGITS via function).
  - function onehot_n(idx) returning an active-low anode vector.
  - typedef nibble_t (logic [3:0]).
- One natural sub-module, seg_tick_gen:
  - Parameter DIV; ports clk, reset, tick, cnt.
  - Instantiated once for the prescaler.
  - The guard comparison uses its cnt output.

Test Plan:
Parameters for all scenarios: NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=1.
- Reset then idle, no load → for 32 cycles digit=0, anode=4'b1111 during guard cycles and the active pattern otherwise. Active patterns cycle 1110, 1101, 1011, 0111. frame_done pulses every 16 cycles.
- load with value=16'hA3F5, mask=0 → digit sequence 5, F, 3, A, aligned with anodes 1110, 1101, 1011, 0111 from the first slot after load.
- mask=4'b0100 with value=16'h1234 → slot idx 2 shows anode=1111 for its whole slot; digit=2 is still driven.
- reset asserted for one cycle while idx=2 and cnt=2 → next cycle cnt=0, idx=0, anode=1111, digit=0, frame_done=0.
- load and tick in the same cycle, value changes 16'h0000 to 16'hFFFF → first displayed nibble of the new slot is F.
- With SEG_SCAN_LEADING_ZERO_BLANK_EN defined, value=16'h0070 → digits 3 and 2 are blanked (anode 1111 in their slots), digit 1 shows 7, digit 0 shows 0 lit. value=16'h0000 → only digit 0 is lit.
